// File: rtl/imm_seq_if.sv
// Handshake bundle between the decoder/prefetch side and the immediate sequencer.
// The master drives instructions, extension words and result acceptance; the slave is imm_seq.
interface imm_seq_if;
    logic        instr_valid;
    logic        instr_ready;
    logic        movei;
    logic [1:0]  op_class;
    logic [4:0]  srcop;
    logic [31:0] program_count;

    logic        ext_valid;
    logic [15:0] ext_data;
    logic        ext_ready;

    logic        imm_valid;
    logic [31:0] imm_data;
    logic        imm_isimm;
    logic        imm_ready;

    modport master (
        output instr_valid, movei, op_class, srcop, program_count,
        output ext_valid, ext_data, imm_ready,
        input  instr_ready, ext_ready, imm_valid, imm_data, imm_isimm
    );

    modport slave (
        input  instr_valid, movei, op_class, srcop, program_count,
        input  ext_valid, ext_data, imm_ready,
        output instr_ready, ext_ready, imm_valid, imm_data, imm_isimm
    );
endinterface

// File: rtl/imm_seq.sv
// Immediate operand sequencer: forms short immediates directly from the instruction,
// or assembles a 32-bit MOVEI operand from two 16-bit extension words (low word first).
module imm_seq (
    input  logic     clk,
    input  logic     resetl,
    input  logic     flush,
    output logic     busy,
    imm_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        instr_fire;
    logic        ext_fire;
    logic [31:0] sext;
    logic [31:0] imm_calc;
    logic        isimm_calc;
    logic [31:0] data_q;
    logic        isimm_q;

    // Reset and flush both veto every handshake so neither side sees a word consumed.
    assign bus.instr_ready = resetl && !flush &&
                             ((state == IDLE) || ((state == OUT) && bus.imm_ready));
    assign bus.ext_ready   = resetl && !flush && ((state == LOW) || (state == HIGH));

    assign instr_fire = bus.instr_valid && bus.instr_ready;
    assign ext_fire   = bus.ext_valid && bus.ext_ready;

    assign bus.imm_valid = (state == OUT);
    assign bus.imm_data  = data_q;
    assign bus.imm_isimm = isimm_q;
    assign busy          = (state != IDLE);

    assign sext = {{27{bus.srcop[4]}}, bus.srcop};

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        imm_calc   = '0;
        isimm_calc = 1'b1;
        case (bus.op_class)
            2'd0: isimm_calc = 1'b0;
            2'd1: imm_calc   = sext;
            2'd2: imm_calc   = (bus.srcop == 5'd0) ? 32'd32 : {27'd0, bus.srcop};
            2'd3: imm_calc   = bus.program_count + {sext[30:0], 1'b0};
            default: imm_calc = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (instr_fire) state_nxt = bus.movei ? LOW : OUT;
            LOW:  if (ext_fire)   state_nxt = HIGH;
            HIGH: if (ext_fire)   state_nxt = OUT;
            OUT: begin
                if (bus.imm_ready) begin
                    if (instr_fire) state_nxt = bus.movei ? LOW : OUT;
                    else            state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order or other always blocks.
    always_ff @(posedge clk) begin
        if (!resetl) state <= IDLE;
        else         state <= state_nxt;
    end

    // A MOVEI accept leaves the result register alone; both halves are overwritten
    // before OUT is reached, and a reset or flush mid-sequence simply restarts at LOW.
    always_ff @(posedge clk) begin
        if (!resetl) begin
            data_q  <= '0;
            isimm_q <= 1'b0;
        end else if (instr_fire) begin
            if (!bus.movei) begin
                data_q  <= imm_calc;
                isimm_q <= isimm_calc;
            end
        end else if (ext_fire) begin
            if (state == LOW) begin
                data_q[15:0] <= bus.ext_data;
            end else begin
                data_q[31:16] <= bus.ext_data;
                isimm_q       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_seq.sv
// Directed bench for imm_seq: expected operands are queued at instruction accept
// and compared when the sequencer presents its result.
module tb_imm_seq;

    typedef struct packed {
        logic [31:0] data;
        logic        isimm;
    } exp_t;

    logic clk;
    logic resetl;
    logic flush;
    logic busy;
    int   checks;
    int   failures;
    exp_t sb[$];

    imm_seq_if bus ();

    imm_seq dut (
        .clk    (clk),
        .resetl (resetl),
        .flush  (flush),
        .busy   (busy),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_imm(input logic [1:0] c, input logic [4:0] s,
                                     input logic [31:0] pc);
        exp_t e;
        logic signed [4:0] ss;
        int sv;
        ss = s;
        sv = ss;
        e.isimm = 1'b1;
        case (c)
            2'd0: begin e.data = 32'h0; e.isimm = 1'b0; end
            2'd1: e.data = 32'(sv);
            2'd2: e.data = (s == 5'd0) ? 32'd32 : 32'(s);
            default: e.data = pc + 32'(sv * 2);
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_instr(input logic mv, input logic [1:0] c, input logic [4:0] s,
                              input logic [31:0] pc);
        int n;
        bus.instr_valid   = 1'b1;
        bus.movei         = mv;
        bus.op_class      = c;
        bus.srcop         = s;
        bus.program_count = pc;
        n = 0;
        @(negedge clk);
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("instr_ready", 32'(bus.instr_ready), 32'd1);
        tick();
        bus.instr_valid = 1'b0;
        if (!mv) sb.push_back(ref_imm(c, s, pc));
    endtask

    task automatic send_ext(input logic [15:0] word, input int gap);
        int n;
        bus.ext_valid = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            check("busy_gap", 32'(busy), 32'd1);
            tick();
        end
        bus.ext_valid = 1'b1;
        bus.ext_data  = word;
        n = 0;
        @(negedge clk);
        while (bus.ext_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ext_ready", 32'(bus.ext_ready), 32'd1);
        check("busy_ext", 32'(busy), 32'd1);
        tick();
        bus.ext_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic take);
        exp_t e;
        int n;
        bus.imm_ready = take;
        n = 0;
        @(negedge clk);
        while (bus.imm_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".valid"}, 32'(bus.imm_valid), 32'd1);
        check({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        check({tag, ".data"}, bus.imm_data, e.data);
        check({tag, ".isimm"}, 32'(bus.imm_isimm), 32'(e.isimm));
        tick();
        bus.imm_ready = 1'b0;
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        resetl            = 1'b0;
        flush             = 1'b0;
        bus.instr_valid   = 1'b0;
        bus.movei         = 1'b0;
        bus.op_class      = 2'd0;
        bus.srcop         = 5'd0;
        bus.program_count = 32'h0;
        bus.ext_valid     = 1'b0;
        bus.ext_data      = 16'h0;
        bus.imm_ready     = 1'b0;

        // Reset state, with an instruction offered to prove it is refused.
        bus.instr_valid = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst.instr_ready", 32'(bus.instr_ready), 32'd0);
        check("rst.imm_valid", 32'(bus.imm_valid), 32'd0);
        check("rst.imm_data", bus.imm_data, 32'h0);
        check("rst.imm_isimm", 32'(bus.imm_isimm), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.ext_ready", 32'(bus.ext_ready), 32'd0);
        tick();
        bus.instr_valid = 1'b0;
        resetl = 1'b1;
        @(negedge clk);
        check("rel.instr_ready", 32'(bus.instr_ready), 32'd1);
        tick();

        // Short immediates, result checked the cycle after acceptance.
        send_instr(1'b0, 2'd1, 5'b11111, 32'h0);
        expect_out("sext_m1", 1'b1);
        send_instr(1'b0, 2'd2, 5'd0, 32'h0);
        expect_out("uns_32", 1'b1);
        send_instr(1'b0, 2'd2, 5'd5, 32'h0);
        expect_out("uns_5", 1'b1);
        send_instr(1'b0, 2'd3, 5'b11110, 32'h00F03000);
        expect_out("pcrel_neg", 1'b1);
        send_instr(1'b0, 2'd3, 5'b00001, 32'hFFFFFFFE);
        expect_out("pcrel_wrap", 1'b1);
        send_instr(1'b0, 2'd0, 5'd9, 32'h12345678);
        expect_out("reg", 1'b1);
        send_instr(1'b0, 2'd1, 5'b01111, 32'h0);
        expect_out("sext_15", 1'b1);

        // Extension words are ignored in IDLE.
        bus.ext_valid = 1'b1;
        bus.ext_data  = 16'hDEAD;
        @(negedge clk);
        check("idle.ext_ready", 32'(bus.ext_ready), 32'd0);
        tick();
        bus.ext_valid = 1'b0;

        // MOVEI with a 3-cycle gap between extension words.
        send_instr(1'b1, 2'd2, 5'd7, 32'h0);
        @(negedge clk);
        check("movei.busy_low", 32'(busy), 32'd1);
        check("movei.valid_low", 32'(bus.imm_valid), 32'd0);
        tick();
        send_ext(16'h5678, 0);
        send_ext(16'h1234, 3);
        sb.push_back('{data: 32'h12345678, isimm: 1'b1});
        bus.ext_valid = 1'b1;
        bus.ext_data  = 16'hFFFF;
        @(negedge clk);
        check("out.ext_ready", 32'(bus.ext_ready), 32'd0);
        check("out.busy", 32'(busy), 32'd1);
        tick();
        bus.ext_valid = 1'b0;
        expect_out("movei", 1'b1);

        // Result held while imm_ready is low, then back-to-back with a new instruction.
        send_instr(1'b0, 2'd1, 5'd3, 32'h0);
        repeat (4) begin
            @(negedge clk);
            check("hold.valid", 32'(bus.imm_valid), 32'd1);
            check("hold.data", bus.imm_data, sb[0].data);
            tick();
        end
        bus.imm_ready     = 1'b1;
        bus.instr_valid   = 1'b1;
        bus.movei         = 1'b0;
        bus.op_class      = 2'd1;
        bus.srcop         = 5'b10000;
        @(negedge clk);
        check("b2b.instr_ready", 32'(bus.instr_ready), 32'd1);
        check("b2b.old_data", bus.imm_data, sb[0].data);
        tick();
        bus.instr_valid = 1'b0;
        bus.imm_ready   = 1'b0;
        void'(sb.pop_front());
        sb.push_back(ref_imm(2'd1, 5'b10000, 32'h0));
        expect_out("b2b", 1'b1);

        // Flush in HIGH beats simultaneous handshakes; next MOVEI restarts cleanly.
        send_instr(1'b1, 2'd0, 5'd0, 32'h0);
        send_ext(16'hAAAA, 0);
        flush           = 1'b1;
        bus.ext_valid   = 1'b1;
        bus.ext_data    = 16'hBBBB;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        check("flush.ext_ready", 32'(bus.ext_ready), 32'd0);
        check("flush.instr_ready", 32'(bus.instr_ready), 32'd0);
        tick();
        flush           = 1'b0;
        bus.ext_valid   = 1'b0;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("flush.busy", 32'(busy), 32'd0);
        check("flush.imm_valid", 32'(bus.imm_valid), 32'd0);
        tick();
        send_instr(1'b1, 2'd0, 5'd0, 32'h0);
        send_ext(16'h0001, 0);
        send_ext(16'h0002, 1);
        sb.push_back('{data: 32'h00020001, isimm: 1'b1});
        expect_out("after_flush", 1'b1);

        // Reset in LOW discards the sequence and clears all outputs.
        send_instr(1'b1, 2'd0, 5'd0, 32'h0);
        resetl        = 1'b0;
        bus.ext_valid = 1'b1;
        bus.ext_data  = 16'h7777;
        @(negedge clk);
        check("rstlow.ext_ready", 32'(bus.ext_ready), 32'd0);
        check("rstlow.instr_ready", 32'(bus.instr_ready), 32'd0);
        tick();
        @(negedge clk);
        check("rstlow.imm_valid", 32'(bus.imm_valid), 32'd0);
        check("rstlow.imm_data", bus.imm_data, 32'h0);
        check("rstlow.imm_isimm", 32'(bus.imm_isimm), 32'd0);
        check("rstlow.busy", 32'(busy), 32'd0);
        check("rstlow.ext_ready2", 32'(bus.ext_ready), 32'd0);
        tick();
        resetl        = 1'b1;
        bus.ext_valid = 1'b0;
        send_instr(1'b1, 2'd0, 5'd0, 32'h0);
        send_ext(16'hBEEF, 0);
        send_ext(16'hCAFE, 0);
        sb.push_back('{data: 32'hCAFEBEEF, isimm: 1'b1});
        expect_out("after_reset", 1'b1);
        @(negedge clk);
        check("end.idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_seq.md
IMM_SEQ -- requirements
Module: imm_seq

Interface
REQ-001 The block SHALL have these ports, one clock domain, reset synchronous active-low:
- clk  in  1  sole clock, all state on rising edge
- resetl  in  1  synchronous active-low reset
- flush  in  1  pipeline flush; aborts any in-progress operand
- instr_valid  in  1  decoded instruction offered
- instr_ready  out  1  instruction accepted when instr_valid && instr_ready
- movei  in  1  instruction is MOVEI; needs two 16-bit extension words
- op_class  in  2  0=register, 1=signed 5-bit, 2=unsigned 1..32, 3=PC-relative
- srcop  in  5  instruction immediate field, srcop[4] MSB
- program_count  in  32  PC of the offered instruction, byte address
- ext_valid  in  1  prefetch extension word offered
- ext_data  in  16  extension word
- ext_ready  out  1  extension word consumed when ext_valid && ext_ready
- imm_valid  out  1  operand result held
- imm_data  out  32  operand value
- imm_isimm  out  1  1 = imm_data replaces register source; 0 = register operand
- imm_ready  in  1  result consumed when imm_valid && imm_ready
- busy  out  1  state != IDLE

Function
REQ-002 The FSM SHALL have states IDLE, LOW, HIGH, OUT, held in a registered state variable.
REQ-003 instr_ready SHALL be 1 only when flush=0 and either state=IDLE, or state=OUT with imm_ready=1.
REQ-004 On accept with movei=0, the result SHALL be registered, and the next state SHALL be OUT, giving imm_valid=1 one cycle after acceptance.
REQ-005 Result for op_class=0 SHALL be imm_data=0x00000000 with imm_isimm=0; all other classes SHALL set imm_isimm=1.
REQ-006 Result for op_class=1 SHALL be srcop sign-extended to 32 bits.
REQ-007 Result for op_class=2 SHALL be srcop zero-extended, with srcop=0 encoding 32 (0x00000020).
REQ-008 Result for op_class=3 SHALL be program_count + (sign-extended srcop << 1), modulo 2^32, with no carry or overflow output.
REQ-009 On accept with movei=1, the next state SHALL be LOW and op_class and srcop SHALL be ignored.
REQ-010 ext_ready SHALL be 1 only in states LOW and HIGH with flush=0.
REQ-011 In LOW, an ext handshake SHALL load imm_data[15:0]=ext_data and move to HIGH; with no handshake, the state SHALL hold.
REQ-012 In HIGH, an ext handshake SHALL load imm_data[31:16]=ext_data, set imm_isimm=1, and move to OUT; with no handshake, the state SHALL hold.
REQ-013 ext_valid SHALL be ignored in IDLE and OUT, and no word SHALL be consumed there.
REQ-014 In OUT, imm_valid=1 and imm_data and imm_isimm SHALL be stable until imm_ready=1.
REQ-015 On imm_ready=1 in OUT, the next state SHALL be IDLE, or the state of a new instruction accepted in the same cycle per REQ-003, giving back-to-back results with no bubble.
REQ-016 flush=1 SHALL force the next state to IDLE and imm_valid to 0 next cycle, from any state.
REQ-017 With flush=1, no instruction or extension word SHALL be accepted that cycle, and flush SHALL have priority over all simultaneous handshakes.
REQ-018 imm_valid SHALL be 1 exactly in OUT, and busy SHALL be 1 exactly when state is not IDLE.
REQ-019 No combinational path SHALL exist from ext_data or srcop to any output; imm_data SHALL be registered.

Reset
REQ-020 With resetl=0 on a clk edge, the next state SHALL be IDLE, with imm_valid=0, imm_data=0x00000000, imm_isimm=0, busy=0, and ext_ready=0.
REQ-021 instr_ready SHALL be 0 while resetl=0 and SHALL be 1 on the first cycle after release if flush=0.
REQ-022 A reset during LOW or HIGH SHALL discard the partial word, and the next MOVEI SHALL start again from LOW.
REQ-023 resetl SHALL take priority over flush and all handshakes.

Verification
REQ-024 The bench SHALL cover: op_class=1, srcop=5'b11111 -> imm_data=0xFFFFFFFF, imm_isimm=1, imm_valid high one cycle after acceptance.
REQ-025 The bench SHALL cover: op_class=2, srcop=0 -> 0x00000020; op_class=2, srcop=5 -> 0x00000005.
REQ-026 The bench SHALL cover: op_class=3, program_count=0x00F03000, srcop=5'b11110 -> 0x00F02FFC; program_count=0xFFFFFFFE, srcop=5'b00001 -> 0x00000000 (wrap).
REQ-027 The bench SHALL cover: MOVEI, then ext words 0x5678 and 0x1234 with a 3-cycle ext_valid gap between them -> imm_data=0x12345678, with busy=1 throughout LOW, HIGH and OUT.
REQ-028 The bench SHALL cover: imm_ready held 0 for 4 cycles in OUT -> result stable; then imm_ready=1 with a new op_class=1 instruction -> that instruction is accepted the same cycle and its imm_valid=1 the next cycle.
REQ-029 The bench SHALL cover: flush in HIGH after low word 0xAAAA, then a new MOVEI with 0x0001 and 0x0002 -> 0x00020001; resetl=0 in LOW -> all outputs at REQ-020 values next cycle.
